// File: rtl/shared_bus_driver.sv
// Round-robin arbitrated tri-state driver for a shared data bus.
// One channel owns the bus for HOLD cycles, then the bus floats for TURN cycles.
module shared_bus_driver #(
    parameter int unsigned W    = 21,
    parameter int unsigned N_CH = 4,
    parameter int unsigned HOLD = 1,
    parameter int unsigned TURN = 1,
    localparam int unsigned SW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*W-1:0] data_in,
    output logic [N_CH-1:0]   ack,
    output logic [W-1:0]      bus,
    output logic              bus_oe,
    output logic [SW-1:0]     bus_src,
    output logic              busy
);

    localparam int unsigned CMAX = (HOLD > TURN) ? HOLD : TURN;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] TURN_LAST = (TURN > 0) ? CW'(TURN - 1) : '0;

    typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     data_q, data_d;
    logic [SW-1:0]    src_q, src_d;
    logic [SW-1:0]    rr_q, rr_d;
    logic [N_CH-1:0]  ack_q, ack_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [SW-1:0]    grant;

    // First requester at or above rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            logic [SW-1:0] cand;
            cand = SW'((int'(rr_q) + k) % int'(N_CH));
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        src_d   = src_q;
        rr_d    = rr_q;
        ack_d   = '0;
        oe_d    = oe_q;
        unique case (state_q)
            StIdle: begin
                if (en && found) begin
                    data_d       = data_in[grant*W +: W];
                    src_d        = grant;
                    oe_d         = 1'b1;
                    ack_d[grant] = 1'b1;
                    rr_d         = (grant == SW'(N_CH - 1)) ? '0 : grant + 1'b1;
                    cnt_d        = '0;
                    state_d      = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == HOLD_LAST) begin
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = (TURN > 0) ? StTurn : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTurn: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                oe_d    = 1'b0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            rr_q    <= '0;
            ack_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign bus_oe  = oe_q;
    assign bus_src = src_q;
    assign busy    = busy_q;
    assign bus     = oe_q ? data_q : {W{1'bz}};

endmodule
